// File: rtl/iq_pkg.sv
// Shared types and helpers for the issue-queue ring.
// Entry layout is {pc, instr}; the NOP fills unused issue slots.
package iq_pkg;
  localparam int ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  localparam entry_t NOP_ENTRY = 64'h0000_0000_0000_0013;

  function automatic int unsigned clamp_min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/iq_ptr_add.sv
// Modulo-DEPTH pointer adder for ring indices; purely combinational.
// Assumes n <= DEPTH, so a single conditional subtraction wraps the sum.
module iq_ptr_add
  import iq_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PW    = 4,
  parameter int NW    = 4
) (
  input  logic [PW-1:0] ptr,
  input  logic [NW-1:0] n,
  output logic [PW-1:0] sum
);
  localparam int SW = ((PW > NW) ? PW : NW) + 1;

  logic [SW-1:0] raw;

  always_comb begin
    raw = SW'(ptr) + SW'(n);
    if (raw >= SW'(DEPTH)) raw = raw - SW'(DEPTH);
  end

  assign sum = raw[PW-1:0];
endmodule

// File: rtl/iq_ring.sv
// Circular instruction queue: variable-width enqueue, up to ISSUE_W oldest entries issued.
// Enqueue-to-issue 1 cycle; in_ready drops when room < clamped in_count, out_valid gated by count.
module iq_ring
  import iq_pkg::*;
#(
  parameter int FETCH_W       = 10,
  parameter int ISSUE_W       = 4,
  parameter int DEPTH         = 16,
  parameter int PARTIAL_ISSUE = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [$clog2(FETCH_W+1)-1:0]     in_count,
  input  logic [ENTRY_W*FETCH_W-1:0]       in_table,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [$clog2(ISSUE_W+1)-1:0]     out_count,
  output logic [ISSUE_W-1:0]               out_slot_valid,
  output logic [ENTRY_W*ISSUE_W-1:0]       out_entries,
  output logic [$clog2(DEPTH+1)-1:0]       room
);
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NIW = $clog2(FETCH_W+1);
  localparam int OCW = $clog2(ISSUE_W+1);
  localparam int CW  = $clog2(DEPTH+1);

  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  entry_t         storage_q [DEPTH];
  entry_t         storage_d [DEPTH];

  logic [NIW-1:0] n_in;
  logic [PW-1:0]  wr_next, rd_next;
  logic [PW-1:0]  wr_idx [FETCH_W];
  logic [PW-1:0]  rd_idx [ISSUE_W];
  logic           enq, deq;

  assign room      = CW'(DEPTH) - count_q;
  assign n_in      = NIW'(clamp_min(32'(in_count), FETCH_W));
  assign in_ready  = 32'(room) >= 32'(n_in);
  assign out_count = OCW'(clamp_min(32'(count_q), ISSUE_W));
  assign out_valid = (PARTIAL_ISSUE != 0) ? (count_q != '0) : (32'(count_q) >= ISSUE_W);
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready && !flush;

  iq_ptr_add #(.DEPTH(DEPTH), .PW(PW), .NW(NIW)) u_wr_next (
    .ptr(wr_ptr_q), .n(n_in), .sum(wr_next)
  );
  iq_ptr_add #(.DEPTH(DEPTH), .PW(PW), .NW(OCW)) u_rd_next (
    .ptr(rd_ptr_q), .n(out_count), .sum(rd_next)
  );

  for (genvar k = 0; k < FETCH_W; k++) begin : g_wr_idx
    iq_ptr_add #(.DEPTH(DEPTH), .PW(PW), .NW(PW)) u_add (
      .ptr(wr_ptr_q), .n(PW'(k)), .sum(wr_idx[k])
    );
  end

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_rd_idx
    iq_ptr_add #(.DEPTH(DEPTH), .PW(PW), .NW(PW)) u_add (
      .ptr(rd_ptr_q), .n(PW'(k)), .sum(rd_idx[k])
    );
  end

  always_comb begin
    out_slot_valid = '0;
    out_entries    = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      out_slot_valid[k] = k < 32'(out_count);
      out_entries[ENTRY_W*k +: ENTRY_W] = out_slot_valid[k] ? storage_q[rd_idx[k]] : NOP_ENTRY;
    end
  end

  // n_in <= FETCH_W <= DEPTH, so the write indices of one transfer never collide.
  always_comb begin
    storage_d = storage_q;
    if (enq) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (k < 32'(n_in)) storage_d[wr_idx[k]] = entry_t'(in_table[ENTRY_W*k +: ENTRY_W]);
      end
    end
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (enq) wr_ptr_d = wr_next;
      if (deq) rd_ptr_d = rd_next;
      count_d = count_q + (enq ? CW'(n_in) : CW'(0)) - (deq ? CW'(out_count) : CW'(0));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage carries no reset; count and pointers alone define validity.
  always_ff @(posedge clk) begin
    storage_q <= storage_d;
  end
endmodule

// File: tb/tb_iq_ring.sv
// Bench for iq_ring: directed vector table, queue-based reference model with random traffic,
// plus a second instance built with PARTIAL_ISSUE = 0.
module tb_iq_ring;
  localparam int FW = 10;
  localparam int IW = 4;
  localparam int DP = 16;
  localparam logic [63:0] NOP = 64'h0000_0000_0000_0013;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   in_count;
  logic [64*FW-1:0] in_table;
  logic [2:0]   out_count;
  logic [IW-1:0] out_slot_valid;
  logic [64*IW-1:0] out_entries;
  logic [4:0]   room;

  logic         fl0, iv0, rdy0, ov0, ordy0;
  logic [3:0]   ic0;
  logic [64*FW-1:0] tbl0;
  logic [2:0]   oc0;
  logic [IW-1:0] osv0;
  logic [64*IW-1:0] oe0;
  logic [4:0]   room0;

  int checks = 0;
  int failures = 0;
  int seq = 0;
  logic [63:0] q[$];

  typedef struct {
    bit v; int c; bit r; bit f; int rdy; int room_a; int oc_a;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  iq_ring #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(DP), .PARTIAL_ISSUE(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_count(in_count), .in_table(in_table), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count), .out_slot_valid(out_slot_valid), .out_entries(out_entries), .room(room)
  );

  iq_ring #(.FETCH_W(FW), .ISSUE_W(IW), .DEPTH(DP), .PARTIAL_ISSUE(0)) dut0 (
    .clk(clk), .rst(rst), .flush(fl0), .in_valid(iv0), .in_ready(rdy0),
    .in_count(ic0), .in_table(tbl0), .out_valid(ov0), .out_ready(ordy0),
    .out_count(oc0), .out_slot_valid(osv0), .out_entries(oe0), .room(room0)
  );

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] mk_entry(input int s);
    return {32'h1000 + 32'(4 * s), 32'(s) ^ 32'h1357_0000};
  endfunction

  // One cycle: drive, compare all outputs against the queue model, clock, update model.
  task automatic step(input bit v, input int c, input bit r, input bit f, input int rdy_exp);
    int n, m_room, m_oc;
    bit m_ov, m_rdy;
    logic [255:0] ee;
    in_valid  = v;
    in_count  = 4'(c);
    out_ready = r;
    flush     = f;
    for (int k = 0; k < FW; k++) in_table[64*k +: 64] = mk_entry(seq + k);
    #2;
    n      = (c > FW) ? FW : c;
    m_room = DP - q.size();
    m_oc   = (q.size() < IW) ? q.size() : IW;
    m_ov   = q.size() != 0;
    m_rdy  = m_room >= n;
    ee = '0;
    for (int k = 0; k < IW; k++) ee[64*k +: 64] = (k < m_oc) ? q[k] : NOP;
    chk("room", 256'(room), 256'(m_room));
    chk("in_ready", 256'(in_ready), 256'(m_rdy));
    chk("out_valid", 256'(out_valid), 256'(m_ov));
    chk("out_count", 256'(out_count), 256'(m_oc));
    chk("out_slot_valid", 256'(out_slot_valid), 256'((1 << m_oc) - 1));
    chk("out_entries", out_entries, ee);
    if (rdy_exp >= 0) chk("in_ready_vec", 256'(in_ready), 256'(rdy_exp));
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (m_ov && r) repeat (m_oc) void'(q.pop_front());
      if (v && m_rdy) for (int k = 0; k < n; k++) q.push_back(mk_entry(seq + k));
    end
    seq += FW;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; flush = 0; in_valid = 0; out_ready = 0; in_count = 0; in_table = '0;
    fl0 = 0; iv0 = 0; ordy0 = 0; ic0 = 0; tbl0 = '0;
    #12;
    chk("rst_room", 256'(room), 256'(16));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_out_count", 256'(out_count), 256'(0));
    chk("rst_slot_valid", 256'(out_slot_valid), 256'(0));
    chk("rst_entries", out_entries, {4{NOP}});
    chk("rst0_room", 256'(room0), 256'(16));
    chk("rst0_out_valid", 256'(ov0), 256'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    tbl.push_back('{1, 6, 0, 0, 1, 10, 4});
    tbl.push_back('{0, 0, 1, 0, 1, 14, 2});
    tbl.push_back('{0, 0, 1, 0, 1, 16, 0});
    tbl.push_back('{1, 10, 0, 0, 1, 6, 4});
    tbl.push_back('{1, 2, 0, 0, 1, 4, 4});
    tbl.push_back('{1, 10, 0, 0, 0, 4, 4});
    tbl.push_back('{1, 10, 1, 0, 0, 8, 4});
    tbl.push_back('{1, 10, 1, 0, 0, 12, 4});
    tbl.push_back('{1, 10, 0, 0, 1, 2, 4});
    tbl.push_back('{0, 0, 1, 0, 1, 6, 4});
    tbl.push_back('{0, 0, 1, 0, 1, 10, 4});
    tbl.push_back('{0, 0, 1, 0, 1, 14, 2});
    tbl.push_back('{0, 0, 1, 0, 1, 16, 0});
    tbl.push_back('{1, 7, 0, 0, 1, 9, 4});
    tbl.push_back('{1, 3, 1, 1, 1, 16, 0});
    tbl.push_back('{0, 0, 1, 0, 1, 16, 0});
    tbl.push_back('{1, 0, 0, 0, 1, 16, 0});
    tbl.push_back('{1, 15, 0, 0, 1, 6, 4});
    tbl.push_back('{1, 6, 0, 0, 1, 0, 4});
    tbl.push_back('{1, 1, 0, 0, 0, 0, 4});
    tbl.push_back('{1, 0, 0, 0, 1, 0, 4});
    tbl.push_back('{0, 0, 1, 0, 1, 4, 4});
    tbl.push_back('{0, 0, 1, 0, 1, 8, 4});
    tbl.push_back('{0, 0, 1, 0, 1, 12, 4});
    tbl.push_back('{0, 0, 1, 0, 1, 16, 0});

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].c, tbl[i].r, tbl[i].f, tbl[i].rdy);
      chk($sformatf("vec%0d_room", i), 256'(room), 256'(tbl[i].room_a));
      chk($sformatf("vec%0d_out_count", i), 256'(out_count), 256'(tbl[i].oc_a));
    end

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
           1'($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0), -1);
    end
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, -1);

    // Threshold-issue instance: a group of 4 must accumulate before anything issues.
    for (int k = 0; k < FW; k++) tbl0[64*k +: 64] = {32'h2000 + 32'(4 * k), 32'h0000_0013};
    iv0 = 1; ic0 = 3; ordy0 = 1;
    @(posedge clk); #1;
    chk("p0_out_valid_3", 256'(ov0), 256'(0));
    chk("p0_room_3", 256'(room0), 256'(13));
    ic0 = 1;
    @(posedge clk); #1;
    chk("p0_out_valid_4", 256'(ov0), 256'(1));
    chk("p0_out_count_4", 256'(oc0), 256'(4));
    chk("p0_slot0", 256'(oe0[63:0]), 256'({32'h2000, 32'h0000_0013}));
    iv0 = 0; ic0 = 0;
    @(posedge clk); #1;
    chk("p0_room_pop", 256'(room0), 256'(16));
    chk("p0_out_valid_pop", 256'(ov0), 256'(0));
    ordy0 = 0;

    // Asynchronous reset in the middle of a transfer.
    step(1, 5, 0, 0, -1);
    in_valid = 1; in_count = 4'd5; out_ready = 0; flush = 0;
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_room", 256'(room), 256'(16));
    chk("mid_rst_out_valid", 256'(out_valid), 256'(0));
    q.delete();
    @(posedge clk); #3;
    rst = 1'b1;
    #3;
    step(0, 0, 0, 0, 1);
    step(1, 4, 0, 0, 1);
    step(0, 0, 1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
